// File: rtl/softmax_input_buffer_pkg.sv
// Shared sizing, types and FSM encoding for the softmax input buffer.
package softmax_pkg;
  localparam int DATAWIDTH = 16;
  localparam int NUM       = 8;
  localparam int ADDRSIZE  = 7;
  localparam int DEPTH     = 2 ** ADDRSIZE;
  localparam int WORDW     = DATAWIDTH * NUM;

  typedef logic [WORDW-1:0]    word_t;
  typedef logic [ADDRSIZE-1:0] addr_t;

  typedef enum logic [2:0] {IDLE, LOAD, INIT, START, BUSY} smx_buf_state_t;

  function automatic logic is_top_addr(addr_t a);
    return a == addr_t'(DEPTH - 1);
  endfunction
endpackage

// File: rtl/softmax_input_buffer_if.sv
// Vector stream handshake into the softmax input buffer.
interface softmax_input_buffer_if;
  import softmax_pkg::*;
  logic  in_valid;
  logic  in_ready;
  logic  in_last;
  word_t in_data;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/softmax_input_buffer_ram.sv
// Buffer storage: one write port, three registered read ports.
// Reset clears only the read registers; array contents survive reset.
module smx_buf_ram
  import softmax_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  we,
  input  addr_t waddr,
  input  word_t wdata,
  input  addr_t raddr0,
  input  addr_t raddr1,
  input  addr_t raddr2,
  output word_t rdata0,
  output word_t rdata1,
  output word_t rdata2
);
  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      rdata0 <= mem[raddr0];
      rdata1 <= mem[raddr1];
      rdata2 <= mem[raddr2];
    end
  end
endmodule

// File: rtl/softmax_input_buffer.sv
// Softmax input buffer: loads a vector stream, then sequences init/start and serves three read ports.
// Optional build macro SMX_BUF_RANGE_CHECK_EN zeroes reads past end_addr and adds sticky rd_oor.
//
// state | meaning
// IDLE  | waiting for first beat (accepted at address 0)
// LOAD  | accepting beats until in_last or the top address
// INIT  | init pulse, start/end addresses valid
// START | start pulse
// BUSY  | buffer held stable until sm_done
module softmax_input_buffer
  import softmax_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  softmax_input_buffer_if.slave   stream,
  input  addr_t                   addr,
  input  addr_t                   sub0_inp_addr,
  input  addr_t                   sub1_inp_addr,
  output word_t                   inp,
  output word_t                   sub0_inp,
  output word_t                   sub1_inp,
  output addr_t                   start_addr,
  output addr_t                   end_addr,
  output logic                    init,
  output logic                    start,
  input  logic                    sm_done,
  output logic                    busy,
  output logic                    trunc
`ifdef SMX_BUF_RANGE_CHECK_EN
  ,
  output logic                    rd_oor
`endif
);
  smx_buf_state_t state, state_nxt;
  addr_t wr_ptr;
  logic  ready_en, ready_st;
  logic  accept, term, first_beat;
  word_t ram_inp, ram_sub0, ram_sub1;

  assign accept     = stream.in_valid && stream.in_ready;
  assign term       = accept && (stream.in_last || is_top_addr(wr_ptr));
  assign first_beat = accept && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = term ? INIT : LOAD;
      LOAD:    if (term)   state_nxt = INIT;
      INIT:    state_nxt = START;
      START:   state_nxt = BUSY;
      BUSY:    if (sm_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    init     = 1'b0;
    start    = 1'b0;
    busy     = 1'b1;
    ready_st = 1'b0;
    case (state)
      IDLE:    begin busy = 1'b0; ready_st = 1'b1; end
      LOAD:    ready_st = 1'b1;
      INIT:    init = 1'b1;
      START:   start = 1'b1;
      default: ;
    endcase
  end

  // ready_en keeps in_ready low for the cycle right after reset
  assign stream.in_ready = ready_st && ready_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      ready_en   <= 1'b0;
      start_addr <= '0;
      end_addr   <= '0;
      trunc      <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (first_beat) trunc <= 1'b0;
      if (term) begin
        wr_ptr     <= '0;
        end_addr   <= wr_ptr;
        start_addr <= '0;
        trunc      <= !stream.in_last;
      end else if (accept) begin
        wr_ptr <= wr_ptr + addr_t'(1);
      end
    end
  end

  smx_buf_ram u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (accept && !reset),
    .waddr  (wr_ptr),
    .wdata  (stream.in_data),
    .raddr0 (addr),
    .raddr1 (sub0_inp_addr),
    .raddr2 (sub1_inp_addr),
    .rdata0 (ram_inp),
    .rdata1 (ram_sub0),
    .rdata2 (ram_sub1)
  );

`ifdef SMX_BUF_RANGE_CHECK_EN
  logic [2:0] oor_now, oor_q;

  assign oor_now = {sub1_inp_addr > end_addr, sub0_inp_addr > end_addr, addr > end_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      oor_q  <= '0;
      rd_oor <= 1'b0;
    end else begin
      oor_q <= oor_now;
      if (first_beat)    rd_oor <= 1'b0;
      else if (|oor_now) rd_oor <= 1'b1;
    end
  end

  assign inp      = oor_q[0] ? '0 : ram_inp;
  assign sub0_inp = oor_q[1] ? '0 : ram_sub0;
  assign sub1_inp = oor_q[2] ? '0 : ram_sub1;
`else
  assign inp      = ram_inp;
  assign sub0_inp = ram_sub0;
  assign sub1_inp = ram_sub1;
`endif
endmodule

// File: tb/tb_softmax_input_buffer.sv
// Directed bench for softmax_input_buffer with a read-data scoreboard.
// Honours SMX_BUF_RANGE_CHECK_EN when defined for the build.
module tb_softmax_input_buffer;
  import softmax_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  addr_t addr, sub0_inp_addr, sub1_inp_addr;
  word_t inp, sub0_inp, sub1_inp;
  addr_t start_addr, end_addr;
  logic  init, start, sm_done, busy, trunc;
`ifdef SMX_BUF_RANGE_CHECK_EN
  logic  rd_oor;
`endif

  int checks = 0;
  int failures = 0;

  word_t mdl [DEPTH];
  int    wp_mdl = 0;
  int    end_mdl = 0;
  word_t exp_q [$];

  softmax_input_buffer_if bus ();

  softmax_input_buffer dut (
    .clk           (clk),
    .reset         (reset),
    .stream        (bus),
    .addr          (addr),
    .sub0_inp_addr (sub0_inp_addr),
    .sub1_inp_addr (sub1_inp_addr),
    .inp           (inp),
    .sub0_inp      (sub0_inp),
    .sub1_inp      (sub1_inp),
    .start_addr    (start_addr),
    .end_addr      (end_addr),
    .init          (init),
    .start         (start),
    .sm_done       (sm_done),
    .busy          (busy),
    .trunc         (trunc)
`ifdef SMX_BUF_RANGE_CHECK_EN
    ,
    .rd_oor        (rd_oor)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WORDW-1:0] obs, input logic [WORDW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic word_t exp_word(input addr_t a);
`ifdef SMX_BUF_RANGE_CHECK_EN
    if (int'(a) > end_mdl) return '0;
`endif
    return mdl[a];
  endfunction

  // drive one beat and hold it until the handshake completes
  task automatic send_beat(input word_t d, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("accept_timeout", {127'b0, bus.in_ready}, 1);
    tick();
    mdl[wp_mdl] = d;
    if (last || wp_mdl == DEPTH - 1) begin
      end_mdl = wp_mdl;
      wp_mdl  = 0;
    end else begin
      wp_mdl++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic rd(input addr_t a0, input addr_t a1, input addr_t a2);
    word_t e;
    addr = a0;
    sub0_inp_addr = a1;
    sub1_inp_addr = a2;
    exp_q.push_back(exp_word(a0));
    exp_q.push_back(exp_word(a1));
    exp_q.push_back(exp_word(a2));
    tick();
    e = exp_q.pop_front(); chk("rd_inp", inp, e);
    e = exp_q.pop_front(); chk("rd_sub0", sub0_inp, e);
    e = exp_q.pop_front(); chk("rd_sub1", sub1_inp, e);
  endtask

  task automatic finish_sm();
    sm_done = 1'b1;
    tick();
    sm_done = 1'b0;
    chk("done_busy", {127'b0, busy}, 0);
    chk("done_ready", {127'b0, bus.in_ready}, 1);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    addr = '0;
    sub0_inp_addr = '0;
    sub1_inp_addr = '0;
    sm_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", {127'b0, busy}, 0);
    chk("rst_ready", {127'b0, bus.in_ready}, 0);
    chk("rst_init", {127'b0, init}, 0);
    chk("rst_start", {127'b0, start}, 0);
    chk("rst_trunc", {127'b0, trunc}, 0);
    chk("rst_end", {121'b0, end_addr}, 0);
    chk("rst_inp", inp, 0);
    reset = 1'b0;

    // four-beat vector, last on D3
    for (int i = 0; i < 4; i++) send_beat(rand_word(), i == 3);
    chk("v4_init", {127'b0, init}, 1);
    chk("v4_start0", {127'b0, start}, 0);
    chk("v4_end", {121'b0, end_addr}, 3);
    chk("v4_startaddr", {121'b0, start_addr}, 0);
    chk("v4_ready_init", {127'b0, bus.in_ready}, 0);
    tick();
    chk("v4_init_off", {127'b0, init}, 0);
    chk("v4_start", {127'b0, start}, 1);
    tick();
    chk("v4_start_off", {127'b0, start}, 0);
    chk("v4_busy", {127'b0, busy}, 1);
    bus.in_valid = 1'b1;
    bus.in_data = rand_word();
    chk("v4_ready_busy", {127'b0, bus.in_ready}, 0);
    tick();
    bus.in_valid = 1'b0;
    rd(2, 0, 2);
    rd(1, 3, 3);
`ifdef SMX_BUF_RANGE_CHECK_EN
    rd(5, 3, 0);
    chk("oor_flag", {127'b0, rd_oor}, 1);
    rd(3, 3, 3);
`endif
    finish_sm();

    // five beats with idle gaps between handshakes
    for (int i = 0; i < 5; i++) begin
      send_beat(rand_word(), i == 4);
`ifdef SMX_BUF_RANGE_CHECK_EN
      if (i == 0) chk("oor_clear", {127'b0, rd_oor}, 0);
`endif
      if (i < 4) repeat ((i % 2) + 1) tick();
    end
    chk("gap_end", {121'b0, end_addr}, 4);
    tick();
    tick();
    rd(0, 1, 2);
    rd(3, 4, 4);
    finish_sm();

    // reset in the middle of a load
    send_beat(rand_word(), 1'b0);
    send_beat(rand_word(), 1'b0);
    reset = 1'b1;
    tick();
    chk("mrst_busy", {127'b0, busy}, 0);
    chk("mrst_ready", {127'b0, bus.in_ready}, 0);
    chk("mrst_end", {121'b0, end_addr}, 0);
    chk("mrst_inp", inp, 0);
    chk("mrst_sub1", sub1_inp, 0);
    reset = 1'b0;
    wp_mdl = 0;
    end_mdl = 0;
    for (int i = 0; i < 3; i++) send_beat(rand_word(), i == 2);
    chk("mrst_newend", {121'b0, end_addr}, 2);
    tick();
    tick();
    rd(2, 1, 0);
    finish_sm();

    // full-depth load without in_last
    for (int i = 0; i < DEPTH; i++) send_beat(rand_word(), 1'b0);
    chk("tr_end", {121'b0, end_addr}, 127);
    chk("tr_flag", {127'b0, trunc}, 1);
    chk("tr_init", {127'b0, init}, 1);
    tick();
    tick();
    rd(127, 0, 64);
    finish_sm();
    chk("tr_sticky", {127'b0, trunc}, 1);
    send_beat(rand_word(), 1'b1);
    chk("one_trunc", {127'b0, trunc}, 0);
    chk("one_end", {121'b0, end_addr}, 0);
    chk("one_init", {127'b0, init}, 1);
    tick();
    tick();
    rd(0, 0, 0);
    finish_sm();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
